// File: rtl/usb_tx_serializer_pkg.sv
// Shared types and constants for the USB TX serializer slice.
// SYNC is sent LSB-first, so 8'h80 goes out on the wire as 0000_0001.
package usb_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      DATA,
      EOP_SE0,
      EOP_J
   } tx_state_t;

   localparam logic [7:0] SYNC_PATTERN = 8'h80;
   localparam int         EOP_SE0_BITS = 2;
   localparam int         EOP_J_BITS   = 1;

endpackage

// File: rtl/usb_tx_serializer_if.sv
// Byte handshake between the packet source and the TX serializer.
// The source owns start/data/valid/last; the serializer answers with ready.
interface usb_tx_if;

   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_data_valid;
   logic       tx_last;
   logic       tx_data_ready;

   modport master (
      output tx_start,
      output tx_data,
      output tx_data_valid,
      output tx_last,
      input  tx_data_ready
   );

   modport slave (
      input  tx_start,
      input  tx_data,
      input  tx_data_valid,
      input  tx_last,
      output tx_data_ready
   );

endinterface

// File: rtl/usb_tx_serializer_bit_timer.sv
// Divides the system clock into USB bit periods.
// The strobe marks the last clock of each bit period while the timer runs.
module usb_bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic n_rst,
   input  logic enable,
   input  logic clear,
   output logic strobe
);

   localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]  LAST_CNT = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= (count == LAST_CNT) ? '0 : count + CW'(1);
      end
   end

   assign strobe = enable && (count == LAST_CNT);

endmodule

// File: rtl/usb_tx_serializer.sv
// TX serializer: SYNC, LSB-first data with bit stuffing, then SE0/J end of packet.
// Line outputs are registered and only change right after a bit strobe.
module usb_tx_serializer
   import usb_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int STUFF_RUN    = 6
) (
   input  logic     clk,
   input  logic     n_rst,
   usb_tx_if.slave  tx_bus,
   output logic     clk12,
   output logic     serial_out,
   output logic     enc_en,
   output logic     stuff_bit_en,
   output logic     eop_en,
   output logic     eop_reset,
   output logic     bytecomplete,
   output logic     tx_busy,
   output logic     tx_underrun
);

   localparam int ONES_W = $clog2(STUFF_RUN + 1);

   tx_state_t         state;
   logic [6:0]        shift_reg;
   logic [2:0]        bit_cnt;
   logic [ONES_W-1:0] ones_cnt;
   logic              last_flag;

   logic start_ok;
   logic stuff_req;
   logic byte_end;
   logic load_slot;

   usb_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
      .clk    (clk),
      .n_rst  (n_rst),
      .enable (tx_busy),
      .clear  (start_ok),
      .strobe (clk12)
   );

   // A stuff request pre-empts the byte boundary, so the load slides to the end of the stuff bit.
   always_comb begin
      start_ok             = tx_bus.tx_start && !tx_busy;
      stuff_req            = clk12 && (state == DATA) && !stuff_bit_en && serial_out
                             && (ones_cnt == ONES_W'(STUFF_RUN - 1));
      byte_end             = clk12 && (bit_cnt == 3'd7)
                             && ((state == SYNC) || ((state == DATA) && !stuff_req));
      load_slot            = byte_end && !((state == DATA) && last_flag);
      tx_bus.tx_data_ready = load_slot && tx_bus.tx_data_valid;
      tx_underrun          = load_slot && !tx_bus.tx_data_valid;
      bytecomplete         = clk12 && (state == DATA) && !stuff_bit_en && (bit_cnt == 3'd7);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state        <= IDLE;
         shift_reg    <= '0;
         bit_cnt      <= '0;
         ones_cnt     <= '0;
         last_flag    <= 1'b0;
         serial_out   <= 1'b1;
         enc_en       <= 1'b0;
         stuff_bit_en <= 1'b0;
         eop_en       <= 1'b0;
         eop_reset    <= 1'b0;
         tx_busy      <= 1'b0;
      end else if (start_ok) begin
         state        <= SYNC;
         shift_reg    <= SYNC_PATTERN[7:1];
         bit_cnt      <= '0;
         ones_cnt     <= '0;
         last_flag    <= 1'b0;
         serial_out   <= SYNC_PATTERN[0];
         enc_en       <= 1'b1;
         stuff_bit_en <= 1'b0;
         eop_en       <= 1'b0;
         eop_reset    <= 1'b0;
         tx_busy      <= 1'b1;
      end else if (clk12) begin
         case (state)
            SYNC, DATA: begin
               if (stuff_req) begin
                  stuff_bit_en <= 1'b1;
                  serial_out   <= 1'b0;
                  ones_cnt     <= '0;
               end else begin
                  stuff_bit_en <= 1'b0;
                  if ((state == DATA) && !stuff_bit_en) begin
                     ones_cnt <= serial_out ? ones_cnt + 1'b1 : '0;
                  end
                  if (bit_cnt != 3'd7) begin
                     bit_cnt    <= bit_cnt + 3'd1;
                     serial_out <= shift_reg[0];
                     shift_reg  <= {1'b0, shift_reg[6:1]};
                  end else if (load_slot && tx_bus.tx_data_valid) begin
                     state      <= DATA;
                     bit_cnt    <= '0;
                     serial_out <= tx_bus.tx_data[0];
                     shift_reg  <= tx_bus.tx_data[7:1];
                     last_flag  <= tx_bus.tx_last;
                  end else begin
                     state      <= EOP_SE0;
                     bit_cnt    <= '0;
                     serial_out <= 1'b1;
                     enc_en     <= 1'b0;
                     eop_en     <= 1'b1;
                  end
               end
            end
            EOP_SE0: begin
               if (bit_cnt == 3'(EOP_SE0_BITS - 1)) begin
                  state     <= EOP_J;
                  bit_cnt   <= '0;
                  eop_en    <= 1'b0;
                  eop_reset <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end
            EOP_J: begin
               if (bit_cnt == 3'(EOP_J_BITS - 1)) begin
                  state     <= IDLE;
                  bit_cnt   <= '0;
                  eop_reset <= 1'b0;
                  tx_busy   <= 1'b0;
               end else begin
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Directed bench for usb_tx_serializer: records the bit stream per strobe
// and compares it against hand-derived sequences.
module tb_usb_tx_serializer;

   logic clk;
   logic n_rst;
   logic clk12, serial_out, enc_en, stuff_bit_en, eop_en, eop_reset;
   logic bytecomplete, tx_busy, tx_underrun;

   usb_tx_if bus ();

   usb_tx_serializer #(.CLKS_PER_BIT(4), .STUFF_RUN(6)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .tx_bus       (bus),
      .clk12        (clk12),
      .serial_out   (serial_out),
      .enc_en       (enc_en),
      .stuff_bit_en (stuff_bit_en),
      .eop_en       (eop_en),
      .eop_reset    (eop_reset),
      .bytecomplete (bytecomplete),
      .tx_busy      (tx_busy),
      .tx_underrun  (tx_underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checkCnt = 0;
   int passCnt  = 0;

   // Per-packet record, one entry per bit strobe
   logic [63:0] encBits;
   logic [63:0] stuffBits;
   int encCnt, se0Bits, jBits, busyCycles, stuffCycles;
   int readyCnt, bcCnt, bcIdx, urCnt, urIdx, eopStart, bitIdx;
   logic packetDone;
   logic [7:0] pkt [0:3];

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCnt++;
      if (observed === expected) passCnt++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
   endtask

   task automatic driveByte(input int idx, input int len, input int dropAt);
      bus.tx_data       = pkt[idx];
      bus.tx_data_valid = (idx < len) && (idx != dropAt);
      bus.tx_last       = (idx == len - 1);
   endtask

   // Sends one packet and services the byte handshake until tx_busy falls
   task automatic applyStimulus(input int len, input logic [7:0] b0, input logic [7:0] b1, input int dropAt);
      int idx;
      int cyc;
      logic advance;
      encBits = '0; stuffBits = '0; encCnt = 0; se0Bits = 0; jBits = 0;
      busyCycles = 0; stuffCycles = 0; readyCnt = 0; bcCnt = 0; bcIdx = -1;
      urCnt = 0; urIdx = -1; eopStart = -1; bitIdx = 0; packetDone = 1'b0;
      pkt[0] = b0; pkt[1] = b1; pkt[2] = 8'h00; pkt[3] = 8'h00;
      idx = 0;
      advance = 1'b0;
      cyc = 0;
      @(negedge clk);
      driveByte(idx, len, dropAt);
      bus.tx_start = 1'b1;
      while (!packetDone && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         bus.tx_start = 1'b0;
         if (tx_busy) busyCycles++;
         if (stuff_bit_en) stuffCycles++;
         if (bus.tx_data_ready) readyCnt++;
         if (bytecomplete) begin bcCnt++; bcIdx = bitIdx; end
         if (tx_underrun) begin urCnt++; urIdx = bitIdx; end
         if (clk12) begin
            if (enc_en) begin
               encBits   = {encBits[62:0], serial_out};
               stuffBits = {stuffBits[62:0], stuff_bit_en};
               encCnt++;
            end
            if (eop_en) begin
               se0Bits++;
               if (eopStart < 0) eopStart = bitIdx;
            end
            if (eop_reset) jBits++;
            bitIdx++;
         end
         if (!tx_busy) packetDone = 1'b1;
         if (advance) begin
            idx++;
            driveByte(idx, len, dropAt);
         end
         advance = bus.tx_data_ready;
      end
      bus.tx_data_valid = 1'b0;
      bus.tx_last       = 1'b0;
      checkOutput("packet_done", 64'(packetDone), 64'd1);
   endtask

   initial begin
      int idleHigh;
      int idleStrobes;
      int idleClk12;

      n_rst = 1'b0;
      bus.tx_start = 1'b0;
      bus.tx_data = 8'h00;
      bus.tx_data_valid = 1'b0;
      bus.tx_last = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_outs",
                  64'({serial_out, enc_en, stuff_bit_en, eop_en, eop_reset, tx_busy,
                       bytecomplete, tx_underrun, clk12, bus.tx_data_ready}),
                  64'b10_0000_0000);
      n_rst = 1'b1;

      // 1: idle after reset
      idleHigh = 0; idleStrobes = 0; idleClk12 = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (serial_out) idleHigh++;
         if (clk12) idleClk12++;
         if (enc_en || stuff_bit_en || eop_en || eop_reset || bytecomplete
             || tx_underrun || tx_busy || bus.tx_data_ready) idleStrobes++;
      end
      checkOutput("idle_serial_high", 64'(idleHigh), 64'd20);
      checkOutput("idle_clk12", 64'(idleClk12), 64'd0);
      checkOutput("idle_strobes", 64'(idleStrobes), 64'd0);

      // 2: single byte A5; SYNC 8 + data 8 + SE0 2 + J 1 = 19 bit periods
      applyStimulus(1, 8'hA5, 8'h00, -1);
      checkOutput("a5_enc_bits", encBits, 64'b0000_0001_1010_0101);
      checkOutput("a5_enc_cnt", 64'(encCnt), 64'd16);
      checkOutput("a5_se0", 64'(se0Bits), 64'd2);
      checkOutput("a5_j", 64'(jBits), 64'd1);
      checkOutput("a5_eop_start", 64'(eopStart), 64'd16);
      checkOutput("a5_busy", 64'(busyCycles), 64'd76);
      checkOutput("a5_ready", 64'(readyCnt), 64'd1);
      checkOutput("a5_bytecomplete", 64'(bcCnt), 64'd1);
      checkOutput("a5_no_stuff", 64'(stuffCycles), 64'd0);
      checkOutput("a5_no_underrun", 64'(urCnt), 64'd0);

      // 3: FF then 01; stuff after the sixth data 1
      applyStimulus(2, 8'hFF, 8'h01, -1);
      checkOutput("ff01_enc_bits", encBits,
                  64'({8'b0000_0001, 6'b11_1111, 1'b0, 2'b11, 8'b1000_0000}));
      checkOutput("ff01_stuff_pos", stuffBits, 64'({14'b0, 1'b1, 10'b0}));
      checkOutput("ff01_stuff_clks", 64'(stuffCycles), 64'd4);
      checkOutput("ff01_eop_start", 64'(eopStart), 64'd25);
      checkOutput("ff01_busy", 64'(busyCycles), 64'd112);
      checkOutput("ff01_ready", 64'(readyCnt), 64'd2);
      checkOutput("ff01_bytecomplete", 64'(bcCnt), 64'd2);

      // 4: FC; six trailing 1s owe a stuff bit before EOP
      applyStimulus(1, 8'hFC, 8'h00, -1);
      checkOutput("fc_enc_bits", encBits, 64'({8'b0000_0001, 8'b0011_1111, 1'b0}));
      checkOutput("fc_stuff_pos", stuffBits, 64'd1);
      checkOutput("fc_bc_idx", 64'(bcIdx), 64'd15);
      checkOutput("fc_eop_start", 64'(eopStart), 64'd17);
      checkOutput("fc_busy", 64'(busyCycles), 64'd80);

      // 5: second byte never becomes valid
      applyStimulus(2, 8'h3C, 8'h55, 1);
      checkOutput("ur_enc_bits", encBits, 64'b0000_0001_0011_1100);
      checkOutput("ur_count", 64'(urCnt), 64'd1);
      checkOutput("ur_idx", 64'(urIdx), 64'd15);
      checkOutput("ur_ready", 64'(readyCnt), 64'd1);
      checkOutput("ur_eop_start", 64'(eopStart), 64'd16);
      checkOutput("ur_se0_j", 64'({se0Bits[3:0], jBits[3:0]}), 64'h21);
      checkOutput("ur_busy", 64'(busyCycles), 64'd76);

      // 6: reset in the middle of data bit 1 of A5
      @(negedge clk);
      bus.tx_data = 8'hA5; bus.tx_data_valid = 1'b1; bus.tx_last = 1'b1;
      bus.tx_start = 1'b1;
      @(negedge clk);
      bus.tx_start = 1'b0;
      repeat (37) @(negedge clk);
      checkOutput("mid_data_state", 64'({serial_out, enc_en, tx_busy}), 64'b011);
      n_rst = 1'b0;
      #1;
      checkOutput("mid_reset_outs",
                  64'({serial_out, enc_en, stuff_bit_en, eop_en, eop_reset, tx_busy,
                       bytecomplete, tx_underrun, clk12, bus.tx_data_ready}),
                  64'b10_0000_0000);
      @(negedge clk);
      bus.tx_data_valid = 1'b0; bus.tx_last = 1'b0;
      n_rst = 1'b1;
      applyStimulus(1, 8'hA5, 8'h00, -1);
      checkOutput("restart_enc_bits", encBits, 64'b0000_0001_1010_0101);
      checkOutput("restart_busy", 64'(busyCycles), 64'd76);

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
